// File: rtl/mem_access_ctrl.sv
// Round-robin sequencer for one single-port sync RAM shared by fetch and the mem stage.
// Loads/fetches take 3 cycles to ack, full stores 2, partial stores 4 (read-modify-write).
module mem_access_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  i_req_i,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  output logic [DATA_WIDTH-1:0] i_rdata_o,
  output logic                  i_ack_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [3:0]            d_be_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  d_ack_o,
  output logic                  stall_o,
  output logic                  ram_ce_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  localparam int LANE_W = DATA_WIDTH / 4;
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

  typedef enum logic [2:0] {IDLE, RD, RDWAIT, WR, ACK} state_e;

  state_e                state_q;
  logic                  owner_data_q;
  logic                  last_data_q;
  logic                  we_q;
  logic [3:0]            be_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  ram_ce_q;
  logic                  ram_we_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_wdata_q;
  logic [DATA_WIDTH-1:0] i_rdata_q;
  logic [DATA_WIDTH-1:0] d_rdata_q;
  logic                  i_ack_q;
  logic                  d_ack_q;

  logic                  gnt_data_d;
  logic [DATA_WIDTH-1:0] merged_d;

  // Data wins unless fetch is also pending and data was the previous winner.
  always_comb begin
    gnt_data_d = d_req_i & (~i_req_i | ~last_data_q);
  end

  always_comb begin
    merged_d = ram_rdata_i;
    for (int k = 0; k < 4; k++) begin
      if (be_q[k]) merged_d[k*LANE_W +: LANE_W] = wdata_q[k*LANE_W +: LANE_W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      owner_data_q <= 1'b0;
      last_data_q  <= 1'b0;
      we_q         <= 1'b0;
      be_q         <= 4'b0000;
      wdata_q      <= '0;
      ram_ce_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
    end else begin
      i_ack_q  <= 1'b0;
      d_ack_q  <= 1'b0;
      ram_ce_q <= 1'b0;
      ram_we_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (d_req_i || i_req_i) begin
            owner_data_q <= gnt_data_d;
            last_data_q  <= gnt_data_d;
            if (gnt_data_d) begin
              we_q       <= d_we_i;
              be_q       <= d_be_i;
              wdata_q    <= d_wdata_i;
              ram_addr_q <= d_addr_i & WORD_MASK;
              if (d_we_i && d_be_i == 4'b0000) begin
                d_ack_q <= 1'b1;
                state_q <= ACK;
              end else if (d_we_i && d_be_i == 4'b1111) begin
                ram_ce_q    <= 1'b1;
                ram_we_q    <= 1'b1;
                ram_wdata_q <= d_wdata_i;
                state_q     <= WR;
              end else begin
                ram_ce_q <= 1'b1;
                state_q  <= RD;
              end
            end else begin
              we_q       <= 1'b0;
              ram_addr_q <= i_addr_i & WORD_MASK;
              ram_ce_q   <= 1'b1;
              state_q    <= RD;
            end
          end
        end
        RD: state_q <= RDWAIT;
        RDWAIT: begin
          if (we_q) begin
            ram_ce_q    <= 1'b1;
            ram_we_q    <= 1'b1;
            ram_wdata_q <= merged_d;
            state_q     <= WR;
          end else begin
            if (owner_data_q) begin
              d_rdata_q <= ram_rdata_i;
              d_ack_q   <= 1'b1;
            end else begin
              i_rdata_q <= ram_rdata_i;
              i_ack_q   <= 1'b1;
            end
            state_q <= ACK;
          end
        end
        WR: begin
          d_ack_q <= 1'b1;
          state_q <= ACK;
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_ce_o    = ram_ce_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign i_rdata_o   = i_rdata_q;
  assign i_ack_o     = i_ack_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_ack_o     = d_ack_q;
  assign stall_o     = d_req_i & ~d_ack_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: behavioural RAM, word-array reference model,
// directed timing/arbitration/reset cases followed by randomized concurrent traffic.
module tb_mem_access_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        i_req_i, d_req_i, d_we_i;
  logic [31:0] i_addr_i, d_addr_i, d_wdata_i;
  logic [3:0]  d_be_i;
  logic [31:0] i_rdata_o, d_rdata_o, ram_addr_o, ram_wdata_o, ram_rdata_i;
  logic        i_ack_o, d_ack_o, stall_o, ram_ce_o, ram_we_o;

  always #5 clk_i = ~clk_i;

  mem_access_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_rdata_o(i_rdata_o), .i_ack_o(i_ack_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_be_i(d_be_i),
    .d_wdata_i(d_wdata_i), .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o), .stall_o(stall_o),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  typedef struct { logic [31:0] rdata; int issue; int lat; } exp_t;
  typedef struct { int cyc; logic we; logic [31:0] addr; logic [31:0] data; } acc_t;

  exp_t        dq[$], iq[$];
  acc_t        alog[$];
  exp_t        me;
  logic [31:0] mem [0:127];
  logic [31:0] ref_mem [0:127];
  logic [31:0] last_ld;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          n;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endfunction

  // Synchronous RAM: read data appears the cycle after a read strobe.
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (ram_ce_o) begin
      if (ram_we_o) mem[ram_addr_o[8:2]] = ram_wdata_o;
      else ram_rdata_i <= mem[ram_addr_o[8:2]];
    end
  end

  always @(negedge clk_i) begin
    if (ram_ce_o) alog.push_back('{cyc, ram_we_o, ram_addr_o, ram_wdata_o});
    if (dq.size() > 0) chk("stall_busy", 32'(stall_o), 32'(!d_ack_o));
    else if (!d_req_i) chk("stall_idle", 32'(stall_o), 32'd0);
    if (d_ack_o) begin
      if (dq.size() == 0) begin
        checks++; failures++;
        $display("FAIL d_ack_unexpected actual=1 required=0");
      end else begin
        me = dq.pop_front();
        chk("d_rdata", d_rdata_o, me.rdata);
        if (me.lat >= 0) chk("d_latency", 32'(cyc - me.issue), 32'(me.lat));
      end
    end
    if (i_ack_o) begin
      if (iq.size() == 0) begin
        checks++; failures++;
        $display("FAIL i_ack_unexpected actual=1 required=0");
      end else begin
        me = iq.pop_front();
        chk("i_rdata", i_rdata_o, me.rdata);
        if (me.lat >= 0) chk("i_latency", 32'(cyc - me.issue), 32'(me.lat));
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge following the ack.
  task automatic do_data(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, input int lat);
    exp_t e;
    logic [31:0] w;
    int t;
    if (!we) begin
      last_ld = ref_mem[addr[8:2]];
    end else begin
      w = ref_mem[addr[8:2]];
      for (int k = 0; k < 4; k++) if (be[k]) w[8*k +: 8] = wd[8*k +: 8];
      ref_mem[addr[8:2]] = w;
    end
    e.rdata = last_ld; e.issue = cyc; e.lat = lat;
    dq.push_back(e);
    d_req_i = 1'b1; d_we_i = we; d_addr_i = addr; d_be_i = be; d_wdata_i = wd;
    t = 0;
    do begin @(negedge clk_i); t++; end while (!d_ack_o && t < 40);
    if (!d_ack_o) begin
      checks++; failures++;
      $display("FAIL d_ack_timeout actual=none required=ack");
    end
    @(posedge clk_i); #1;
    d_req_i = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] addr, input int lat);
    exp_t e;
    int t;
    e.rdata = ref_mem[addr[8:2]]; e.issue = cyc; e.lat = lat;
    iq.push_back(e);
    i_req_i = 1'b1; i_addr_i = addr;
    t = 0;
    do begin @(negedge clk_i); t++; end while (!i_ack_o && t < 40);
    if (!i_ack_o) begin
      checks++; failures++;
      $display("FAIL i_ack_timeout actual=none required=ack");
    end
    @(posedge clk_i); #1;
    i_req_i = 1'b0;
  endtask

  task automatic chk_acc(input string nm, input int idx, input int c, input logic we,
                         input logic [31:0] a, input logic [31:0] d, input bit cd);
    if (idx >= alog.size()) begin
      checks++; failures++;
      $display("FAIL %s actual=missing required=ram_access", nm);
    end else begin
      chk({nm, "_cyc"}, 32'(alog[idx].cyc), 32'(c));
      chk({nm, "_we"}, 32'(alog[idx].we), 32'(we));
      chk({nm, "_addr"}, alog[idx].addr, a);
      if (cd) chk({nm, "_data"}, alog[idx].data, d);
    end
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_ce"}, 32'(ram_ce_o), 0);
    chk({nm, "_we"}, 32'(ram_we_o), 0);
    chk({nm, "_iack"}, 32'(i_ack_o), 0);
    chk({nm, "_dack"}, 32'(d_ack_o), 0);
    chk({nm, "_addr"}, ram_addr_o, 0);
    chk({nm, "_wdata"}, ram_wdata_o, 0);
    chk({nm, "_irdata"}, i_rdata_o, 0);
    chk({nm, "_drdata"}, d_rdata_o, 0);
    chk({nm, "_stall"}, 32'(stall_o), 0);
  endtask

  initial begin
    int nw;
    for (int i = 0; i < 128; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'hA1B2C3D4; ref_mem[4] = 32'hA1B2C3D4;
    rst_i = 1'b1; i_req_i = 1'b0; d_req_i = 1'b0; d_we_i = 1'b0;
    i_addr_i = '0; d_addr_i = '0; d_wdata_i = '0; d_be_i = '0; last_ld = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk_outputs_zero("reset");
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    alog.delete(); n = cyc;
    do_data(1'b0, 32'h10, 4'hF, 32'h0, 3);
    chk("ld_nacc", 32'(alog.size()), 1);
    chk_acc("ld_rd", 0, n + 1, 1'b0, 32'h10, 0, 1'b0);

    alog.delete(); n = cyc;
    do_data(1'b1, 32'h20, 4'hF, 32'h11223344, 2);
    chk("stf_nacc", 32'(alog.size()), 1);
    chk_acc("stf_wr", 0, n + 1, 1'b1, 32'h20, 32'h11223344, 1'b1);
    do_data(1'b0, 32'h20, 4'hF, 32'h0, 3);
    chk("stf_readback", d_rdata_o, 32'h11223344);

    do_data(1'b1, 32'h20, 4'hF, 32'hAABBCCDD, 2);
    alog.delete(); n = cyc;
    do_data(1'b1, 32'h20, 4'b0100, 32'h00EE0000, 4);
    chk("stp_nacc", 32'(alog.size()), 2);
    chk_acc("stp_rd", 0, n + 1, 1'b0, 32'h20, 0, 1'b0);
    chk_acc("stp_wr", 1, n + 3, 1'b1, 32'h20, 32'hAAEECCDD, 1'b1);
    alog.delete(); n = cyc;
    do_data(1'b1, 32'h21, 4'b0110, 32'h00556600, 4);
    chk_acc("sth_wr", 1, n + 3, 1'b1, 32'h20, 32'hAA5566DD, 1'b1);
    do_data(1'b0, 32'h20, 4'hF, 32'h0, 3);

    alog.delete();
    do_data(1'b1, 32'h30, 4'b0000, $urandom, 1);
    chk("st0_nacc", 32'(alog.size()), 0);

    // Reset lands on the RDWAIT cycle of a partial store.
    do_data(1'b1, 32'h24, 4'hF, 32'h01020304, 2);
    alog.delete(); n = cyc;
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h24; d_be_i = 4'b0011; d_wdata_i = '1;
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b1; d_req_i = 1'b0;
    @(posedge clk_i); @(negedge clk_i);
    chk_outputs_zero("midrst");
    @(posedge clk_i); #1;
    rst_i = 1'b0; last_ld = '0;
    @(negedge clk_i);
    chk("midrst_idle_ce", 32'(ram_ce_o), 0);
    nw = 0;
    foreach (alog[k]) if (alog[k].we) nw++;
    chk("midrst_nowrite", 32'(nw), 0);
    chk("midrst_mem", mem[9], 32'h01020304);
    @(posedge clk_i); #1;

    // Arbitration after reset: data, data, then (after a data-only grant) fetch first.
    fork
      do_data(1'b0, 32'h40, 4'hF, 32'h0, 3);
      do_fetch(32'h104, 7);
    join
    fork
      do_data(1'b0, 32'h44, 4'hF, 32'h0, 3);
      do_fetch(32'h10B, 7);
    join
    do_data(1'b0, 32'h48, 4'hF, 32'h0, 3);
    fork
      do_data(1'b0, 32'h4C, 4'hF, 32'h0, 7);
      do_fetch(32'h110, 3);
    join

    fork
      begin
        for (int k = 0; k < 80; k++) begin
          do_data(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
                  4'($urandom_range(0, 15)), $urandom, -1);
          repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
        end
      end
      begin
        for (int j = 0; j < 60; j++) begin
          do_fetch(32'h100 + 32'($urandom_range(0, 255)), -1);
          repeat ($urandom_range(0, 3)) begin @(posedge clk_i); #1; end
        end
      end
    join

    repeat (4) @(posedge clk_i);
    for (int i = 0; i < 128; i++) chk("mem_final", mem[i], ref_mem[i]);
    chk("dq_drained", 32'(dq.size()), 0);
    chk("iq_drained", 32'(iq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequencer and arbiter for the single-port synchronous data/instruction RAM behind the pipeline. Accepts word reads from instruction fetch and lane-aligned reads/writes with byte enables from the mem stage. Grants the RAM round-robin and performs read-modify-write for partial stores, so the mem stage no longer merges bytes combinationally. Drives a stall to the pipeline while a data access is outstanding.

Parameters:
ADDR_WIDTH, 32, RAM/request address width (byte address; RAM uses word address = addr[ADDR_WIDTH-1:2])
DATA_WIDTH, 32, data width; fixed 4 byte lanes

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous active-high reset
i_req_i  in  1  instruction fetch request, held until i_ack_o
i_addr_i  in  ADDR_WIDTH  fetch byte address (word aligned)
i_rdata_o  out  DATA_WIDTH  fetched word, valid when i_ack_o
i_ack_o  out  1  one-cycle completion pulse
d_req_i  in  1  data request, held stable until d_ack_o
d_we_i  in  1  1=store, 0=load
d_addr_i  in  ADDR_WIDTH  data byte address
d_be_i  in  4  byte-lane enables for stores (bit k = bits 8k+7:8k)
d_wdata_i  in  DATA_WIDTH  store data, already lane-aligned
d_rdata_o  out  DATA_WIDTH  full loaded word, valid when d_ack_o; mem stage extracts/extends
d_ack_o  out  1  one-cycle completion pulse
stall_o  out  1  d_req_i & ~d_ack_o
ram_ce_o  out  1  RAM chip enable
ram_we_o  out  1  RAM write enable
ram_addr_o  out  ADDR_WIDTH  RAM byte address
ram_wdata_o  out  DATA_WIDTH  RAM write data
ram_rdata_i  in  DATA_WIDTH  RAM read data, valid the cycle after ram_ce_o=1, ram_we_o=0

Behaviour:
- Reset: state IDLE; ram_ce_o/ram_we_o/i_ack_o/d_ack_o 0; ram_addr_o, ram_wdata_o, i_rdata_o, d_rdata_o 0; last_grant = instruction. Reset mid-operation aborts the access; no ram_we_o in the cycle after reset. All ram_* outputs are registered/state-decoded, no input-to-RAM combinational path.
- States: IDLE, RD, RDWAIT, WR, ACK.
- IDLE: sample requests; latch addr/we/be/wdata and owner. Both pending: grant the one not granted last. Only one pending: grant it. Update last_grant on grant.
- Data load or instruction fetch: IDLE(N) -> RD(N+1: ce=1, we=0, addr) -> RDWAIT(N+2: capture ram_rdata_i) -> ACK(N+3: owner ack=1, rdata valid) -> IDLE.
- Store, be=4'b1111: IDLE(N) -> WR(N+1: ce=1, we=1, wdata=d_wdata_i) -> ACK(N+2).
- Store, partial be (not 0000/1111): IDLE(N) -> RD(N+1) -> RDWAIT(N+2: merge, lane k = be[k] ? wdata lane k : rdata lane k) -> WR(N+3, merged data) -> ACK(N+4). Any be pattern is legal, including misaligned halfwords.
- Store, be=4'b0000: IDLE -> ACK directly, no RAM access.
- Store address: ram_addr_o = {addr[ADDR_WIDTH-1:2],2'b00}. Fetch addr[1:0] ignored.
- ram_ce_o=0 and ram_we_o=0 in IDLE, RDWAIT, ACK.
- i_rdata_o/d_rdata_o hold last value between acks. d_rdata_o unchanged on store ack.
- Requester must drop or change req in the cycle after ack. A req still high in IDLE is a new request.
- Request deasserted before ack (protocol violation): access still completes; ack still pulses.

Test Plan:
- Reset, then d_req load addr 0x10, RAM word[4]=0xA1B2C3D4 -> RAM read cycle N+1, d_ack_o=1 and d_rdata_o=0xA1B2C3D4 at N+3; stall_o=1 from N to N+2.
- Store be=1111 addr 0x20 data 0x11223344 -> single ram_we_o pulse at N+1, ack N+2; readback 0x11223344.
- Word 0x20=0xAABBCCDD, store be=0100 data 0x00EE0000 -> read N+1, write 0xAAEECCDD at N+3, ack N+4.
- i_req and d_req asserted same cycle after reset (last_grant=instr) -> data served first. Fetch granted in the IDLE after data ack. Next simultaneous pair, with last grant instruction -> data first. Check alternation.
- Store be=0000 -> ack at N+1, ram_ce_o never asserted.
- rst_i asserted during the RDWAIT cycle of a partial store -> no ram_we_o, RAM word unchanged, all outputs 0, IDLE next cycle.
